// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
// CPU load/store bus bundle for the UART transmit controller.
//   sel   : access strobe, one cycle per access
//   we    : 1 = write, 0 = read (qualified by sel)
//   addr  : byte offset (0x0 TXDATA, 0x4 STATUS, 0x8 CTRL, 0xC IRQSTAT)
//   wdata : write data
//   rdata : registered read data returned by the controller
// Modports: master = CPU side, slave = controller side.
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Memory-mapped transmit controller: buffers CPU-written bytes in a FIFO and
// launches them one frame at a time into the UART transmitter using a
// start/busy handshake. Provides STATUS/CTRL/IRQSTAT registers and a level
// interrupt for "TX drained", "overflow" and (optionally) "timeout".
// Ports:
//   clock     : system clock
//   nRst      : asynchronous active-low reset
//   bus       : CPU bus (uart_tx_ctrl_if.slave): sel, we, addr, wdata, rdata
//   tx_data   : byte presented to the transmitter, held for the whole frame
//   tx_start  : one-cycle frame start request
//   tx_busy   : transmitter frame in progress
//   interrupt : registered level interrupt (irq_en & |IRQSTAT)
// Build option: define UART_TX_CTRL_TIMEOUT_EN to add a 16-cycle watchdog on
// the wait for tx_busy; the stalled byte is dropped and IRQSTAT[2] is set.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clock,
  input  logic           nRst,
  uart_tx_ctrl_if.slave  bus,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           tx_busy,
  output logic           interrupt
);

  localparam int              PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]      ADDR_TXDATA = 4'h0;
  localparam logic [3:0]      ADDR_STATUS = 4'h4;
  localparam logic [3:0]      ADDR_CTRL   = 4'h8;
  localparam logic [3:0]      ADDR_IRQ    = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             tx_en_r;
  logic             irq_en_r;
  logic [2:0]       irq_r;
  logic [31:0]      rdata_r;
`ifdef UART_TX_CTRL_TIMEOUT_EN
  logic [3:0]       tmo_cnt_r;
`endif

  logic        full_s, empty_s, busy_s;
  logic        wr_data_s, wr_ctrl_s, wr_irq_s, rd_s;
  logic        launch_s, push_s, ovf_set_s, drain_set_s, tmo_fire_s;
  logic [2:0]  irq_clr_s, irq_next_s;
  logic [31:0] rd_mux_s;
  logic        unused_s;

  assign full_s      = (count_r == FULL_CNT);
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign busy_s      = (state_r != ST_IDLE) | tx_busy;
  assign wr_data_s   = bus.sel & bus.we & (bus.addr == ADDR_TXDATA);
  assign wr_ctrl_s   = bus.sel & bus.we & (bus.addr == ADDR_CTRL);
  assign wr_irq_s    = bus.sel & bus.we & (bus.addr == ADDR_IRQ);
  assign rd_s        = bus.sel & ~bus.we;
  assign unused_s    = ^bus.wdata[31:8];

  // Launch pops the head; a push while full is still accepted if a pop
  // frees the slot in the same cycle.
  assign launch_s    = (state_r == ST_IDLE) & tx_en_r & ~empty_s & ~tx_busy;
  assign push_s      = wr_data_s & (~full_s | launch_s);
  assign ovf_set_s   = wr_data_s & full_s & ~launch_s;
  assign drain_set_s = (state_r == ST_WAIT_DONE) & ~tx_busy & empty_s;
`ifdef UART_TX_CTRL_TIMEOUT_EN
  assign tmo_fire_s  = (state_r == ST_WAIT_BUSY) & ~tx_busy & (tmo_cnt_r == 4'd15);
`else
  assign tmo_fire_s  = 1'b0;
`endif

  // IRQSTAT next value: W1C clear first, then events set (set wins)
  always_comb begin
    irq_clr_s  = 3'b000;
    if (wr_irq_s) begin
      irq_clr_s = bus.wdata[2:0];
    end else begin
      irq_clr_s = 3'b000;
    end
    irq_next_s = (irq_r & ~irq_clr_s) | {tmo_fire_s, ovf_set_s, drain_set_s};
  end

  // Read data multiplexer
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.addr)
      ADDR_STATUS: begin
        rd_mux_s[11:4] = 8'(count_r);
        rd_mux_s[2]    = busy_s;
        rd_mux_s[1]    = empty_s;
        rd_mux_s[0]    = full_s;
      end
      ADDR_CTRL:   rd_mux_s[1:0] = {irq_en_r, tx_en_r};
      ADDR_IRQ:    rd_mux_s[2:0] = irq_r;
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Transmit sequencer with registered tx_data / tx_start
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state_r   <= ST_IDLE;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
`ifdef UART_TX_CTRL_TIMEOUT_EN
      tmo_cnt_r <= 4'd0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            tx_data   <= fifo_mem_r[rd_ptr_r];
            tx_start  <= 1'b1;
            state_r   <= ST_WAIT_BUSY;
`ifdef UART_TX_CTRL_TIMEOUT_EN
            tmo_cnt_r <= 4'd0;
`endif
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state_r <= ST_WAIT_DONE;
          end
`ifdef UART_TX_CTRL_TIMEOUT_EN
          else if (tmo_fire_s) begin
            state_r <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 4'd1;
          end
`endif
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; reset flushes the queue
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (launch_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, launch_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage (contents need no reset; occupancy is tracked separately)
  always_ff @(posedge clock) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= bus.wdata[7:0];
  end

  // Control/status registers, read data and interrupt
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      tx_en_r   <= 1'b0;
      irq_en_r  <= 1'b0;
      irq_r     <= 3'b000;
      rdata_r   <= 32'h0000_0000;
      interrupt <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        tx_en_r  <= bus.wdata[0];
        irq_en_r <= bus.wdata[1];
      end
      if (rd_s) rdata_r <= rd_mux_s;
      irq_r     <= irq_next_s;
      interrupt <= irq_en_r & (|irq_r);
    end
  end

  assign bus.rdata = rdata_r;

endmodule
